// File: rtl/ll_reader_pkg.sv
// Shared definitions for the linked-list engines: default widths, the
// terminating pointer, FSM state encodings and the list-length guard.
package ll_reader_pkg;

    localparam int LL_DATA_W = 8;
    localparam int LL_ADDR_W = 4;

    // All-ones pointer marks the end of a list.
    localparam logic [LL_ADDR_W-1:0] LL_NULL_PTR = {LL_ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } ll_state_t;

    // A list can never hold more nodes than the memory has entries, so a
    // walk that visits this many nodes without meeting the terminator is
    // corrupt or looped. The insert logic uses the same limit.
    function automatic int ll_len_guard(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/ll_reader_m_ff.sv
// Load-enabled register with asynchronous active-low clear, used for the
// traversal pointer and the captured node fields.
module m_ff #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Hold the value until the enable loads a new one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

    // An unknown enable would silently corrupt the stored value.
    a_enKnown: assert property (@(posedge i_clk) disable iff (!i_rst_n) !$isunknown(i_en));

endmodule

// File: rtl/ll_reader.sv
// Linked-list traversal engine: walks a chain in node memory from a head
// pointer and streams each payload out over valid/ready, flagging the last
// node, pulsing done at the end or error when the length guard trips.
module ll_reader
    import ll_reader_pkg::*;
#(
    parameter int                DATA_W   = LL_DATA_W,
    parameter int                ADDR_W   = LL_ADDR_W,
    parameter logic [ADDR_W-1:0] NULL_PTR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_head_ptr,
    output logic              o_busy,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    input  logic [ADDR_W-1:0] i_mem_rd_next,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_last,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [ADDR_W:0] LEN_GUARD = (ADDR_W+1)'(ll_len_guard(ADDR_W));

    ll_state_t         r_state;
    ll_state_t         w_stateNext;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_nextQ;
    logic [DATA_W-1:0] r_dataQ;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_error;

    logic              w_ptrEn;
    logic [ADDR_W-1:0] w_ptrD;
    logic              w_capEn;
    logic              w_countClr;
    logic              w_countInc;
    logic              w_doneNext;
    logic              w_errorNext;
    logic              w_isLast;

    assign w_isLast = (r_nextQ == NULL_PTR);

    m_ff #(.W(ADDR_W)) u_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_ptrEn),
        .i_d     (w_ptrD),
        .o_q     (r_ptr)
    );

    m_ff #(.W(DATA_W)) u_dataQ (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_capEn),
        .i_d     (i_mem_rd_data),
        .o_q     (r_dataQ)
    );

    m_ff #(.W(ADDR_W)) u_nextQ (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_capEn),
        .i_d     (i_mem_rd_next),
        .o_q     (r_nextQ)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode plus the load strobes and end-of-walk pulses.
    always_comb begin
        w_stateNext = r_state;
        w_ptrEn     = 1'b0;
        w_ptrD      = r_ptr;
        w_capEn     = 1'b0;
        w_countClr  = 1'b0;
        w_countInc  = 1'b0;
        w_doneNext  = 1'b0;
        w_errorNext = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_head_ptr == NULL_PTR) begin
                        w_doneNext = 1'b1;
                    end else begin
                        w_ptrEn     = 1'b1;
                        w_ptrD      = i_head_ptr;
                        w_countClr  = 1'b1;
                        w_stateNext = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                w_capEn     = 1'b1;
                w_countInc  = 1'b1;
                w_stateNext = ST_OUT;
            end
            ST_OUT: begin
                if (i_out_ready) begin
                    if (w_isLast) begin
                        w_doneNext  = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else if (r_count == LEN_GUARD) begin
                        w_errorNext = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_ptrEn     = 1'b1;
                        w_ptrD      = r_nextQ;
                        w_stateNext = ST_REQ;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Node counter: cleared on a new walk, bumped as each node is captured.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_countClr) begin
            r_count <= '0;
        end else if (w_countInc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Registered completion pulses, one cycle after the deciding event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= w_doneNext;
            r_error <= w_errorNext;
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_mem_rd_en   = (r_state == ST_REQ);
    assign o_mem_rd_addr = r_ptr;
    assign o_out_valid   = (r_state == ST_OUT);
    assign o_out_data    = r_dataQ;
    assign o_out_last    = w_isLast;
    assign o_done        = r_done;
    assign o_error       = r_error;

endmodule

// File: tb/tb_ll_reader.sv
// Bench for ll_reader: a synchronous-read node memory model, a scoreboard
// of expected payloads built by walking the bench's own copy of the lists,
// and one task per scenario.
module tb_ll_reader;

    localparam int          DATA_W   = 8;
    localparam int          ADDR_W   = 4;
    localparam logic [3:0]  NULL_PTR = 4'hF;
    localparam int          DEPTH    = 16;

    logic              clk = 1'b0;
    logic              rstN;
    logic              start;
    logic [ADDR_W-1:0] headPtr;
    logic              busy;
    logic              memRdEn;
    logic [ADDR_W-1:0] memRdAddr;
    logic [DATA_W-1:0] memRdData;
    logic [ADDR_W-1:0] memRdNext;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic              outLast;
    logic              done;
    logic              error;

    logic [DATA_W-1:0] memData [DEPTH];
    logic [ADDR_W-1:0] memNext [DEPTH];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } expItem_t;

    expItem_t expQ[$];
    expItem_t monExp;

    int checkCount = 0;
    int passCount  = 0;
    int doneSeen   = 0;
    int errorSeen  = 0;

    ll_reader dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_start       (start),
        .i_head_ptr    (headPtr),
        .o_busy        (busy),
        .o_mem_rd_en   (memRdEn),
        .o_mem_rd_addr (memRdAddr),
        .i_mem_rd_data (memRdData),
        .i_mem_rd_next (memRdNext),
        .o_out_valid   (outValid),
        .i_out_ready   (outReady),
        .o_out_data    (outData),
        .o_out_last    (outLast),
        .o_done        (done),
        .o_error       (error)
    );

    always #5 clk = ~clk;

    // Node memory with one cycle of read latency.
    always @(posedge clk) begin
        if (memRdEn) begin
            memRdData <= memData[memRdAddr];
            memRdNext <= memNext[memRdAddr];
        end
    end

    // Output monitor: every accepted payload must match the scoreboard head.
    always @(negedge clk) begin
        if (rstN) begin
            if (outValid && outReady) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL payload_unexpected: got data=%h last=%b, scoreboard empty", outData, outLast);
                end else begin
                    monExp = expQ.pop_front();
                    if ({outData, outLast} !== {monExp.data, monExp.last})
                        $display("[TB] FAIL payload: got data=%h last=%b, want data=%h last=%b",
                                 outData, outLast, monExp.data, monExp.last);
                    else
                        passCount++;
                end
            end
            if (done || error) begin
                checkCount++;
                if ((done && error) || outValid)
                    $display("[TB] FAIL end_exclusive: done=%b error=%b valid=%b, want one of done/error alone",
                             done, error, outValid);
                else
                    passCount++;
            end
            if (done)  doneSeen++;
            if (error) errorSeen++;
        end
    end

    // Reference walk of the bench memory, pushing what the DUT should emit.
    task automatic pushExpected(input logic [ADDR_W-1:0] head);
        logic [ADDR_W-1:0] p;
        int                cnt;
        expItem_t          item;
        p   = head;
        cnt = 0;
        while (p != NULL_PTR) begin
            item.data = memData[p];
            item.last = (memNext[p] == NULL_PTR);
            expQ.push_back(item);
            cnt++;
            if (memNext[p] == NULL_PTR || cnt == DEPTH) break;
            p = memNext[p];
        end
    endtask

    // Bounded wait for the end of a walk: 0 timeout, 1 done, 2 error.
    task automatic waitEvent(input int maxCycles, output int kind);
        kind = 0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (done)  begin kind = 1; break; end
            if (error) begin kind = 2; break; end
        end
    endtask

    task automatic applyStart(input logic [ADDR_W-1:0] head);
        @(negedge clk);
        start   = 1'b1;
        headPtr = head;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1;
        checkCount++;
        if ({busy, memRdEn, memRdAddr, outValid, outData, outLast, done, error} !== '0)
            $display("[TB] FAIL reset_outputs: got busy=%b rden=%b addr=%h valid=%b data=%h last=%b done=%b err=%b, want all 0",
                     busy, memRdEn, memRdAddr, outValid, outData, outLast, done, error);
        else
            passCount++;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkCount++;
        if ({busy, memRdEn, outValid, done, error} !== '0)
            $display("[TB] FAIL reset_release: got busy=%b rden=%b valid=%b done=%b err=%b, want all 0",
                     busy, memRdEn, outValid, done, error);
        else
            passCount++;
    endtask

    task automatic test_basic();
        pushExpected(4'd3);
        applyStart(4'd3);
        checkCount++;
        if (memRdEn !== 1'b1 || memRdAddr !== 4'd3 || busy !== 1'b1)
            $display("[TB] FAIL basic_c1_read: got rden=%b addr=%h busy=%b, want 1/3/1", memRdEn, memRdAddr, busy);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (outValid !== 1'b0 || memRdEn !== 1'b0)
            $display("[TB] FAIL basic_c2_wait: got valid=%b rden=%b, want 0/0", outValid, memRdEn);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (outValid !== 1'b1 || outData !== 8'hA1 || outLast !== 1'b0)
            $display("[TB] FAIL basic_c3_out: got valid=%b data=%h last=%b, want 1/a1/0", outValid, outData, outLast);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (memRdEn !== 1'b1 || memRdAddr !== 4'd7)
            $display("[TB] FAIL basic_c4_read: got rden=%b addr=%h, want 1/7", memRdEn, memRdAddr);
        else passCount++;
        repeat (2) @(negedge clk);
        checkCount++;
        if (outValid !== 1'b1 || outData !== 8'hB2 || outLast !== 1'b1)
            $display("[TB] FAIL basic_c6_out: got valid=%b data=%h last=%b, want 1/b2/1", outValid, outData, outLast);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (done !== 1'b1 || busy !== 1'b0 || outValid !== 1'b0)
            $display("[TB] FAIL basic_c7_done: got done=%b busy=%b valid=%b, want 1/0/0", done, busy, outValid);
        else passCount++;
        #1;
        checkCount++;
        if (expQ.size() != 0)
            $display("[TB] FAIL basic_drain: got %0d pending, want 0", expQ.size());
        else passCount++;
    endtask

    task automatic test_empty();
        int doneBase;
        doneBase = doneSeen;
        applyStart(NULL_PTR);
        checkCount++;
        if (done !== 1'b1 || busy !== 1'b0 || memRdEn !== 1'b0 || outValid !== 1'b0)
            $display("[TB] FAIL empty_c1: got done=%b busy=%b rden=%b valid=%b, want 1/0/0/0", done, busy, memRdEn, outValid);
        else passCount++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCount++;
            if (busy !== 1'b0 || memRdEn !== 1'b0 || outValid !== 1'b0 || done !== 1'b0)
                $display("[TB] FAIL empty_quiet: got busy=%b rden=%b valid=%b done=%b, want 0/0/0/0", busy, memRdEn, outValid, done);
            else passCount++;
        end
        #1;
        checkCount++;
        if (doneSeen - doneBase != 1)
            $display("[TB] FAIL empty_done_count: got %0d, want 1", doneSeen - doneBase);
        else passCount++;
    endtask

    task automatic test_backpressure();
        int  kind;
        bit  seen;
        @(posedge clk) #1 outReady = 1'b0;
        pushExpected(4'd3);
        applyStart(4'd3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (outValid) seen = 1'b1;
            else @(negedge clk);
        end
        checkCount++;
        if (!seen) $display("[TB] FAIL bp_valid_timeout: got no valid, want valid within 10 cycles");
        else passCount++;
        for (int i = 0; i < 5; i++) begin
            checkCount++;
            if (outValid !== 1'b1 || outData !== 8'hA1 || memRdEn !== 1'b0)
                $display("[TB] FAIL bp_hold: got valid=%b data=%h rden=%b, want 1/a1/0", outValid, outData, memRdEn);
            else passCount++;
            @(negedge clk);
        end
        @(posedge clk) #1 outReady = 1'b1;
        waitEvent(20, kind);
        checkCount++;
        if (kind != 1) $display("[TB] FAIL bp_end: got kind=%0d, want 1 (done)", kind);
        else passCount++;
        #1;
        checkCount++;
        if (expQ.size() != 0) $display("[TB] FAIL bp_drain: got %0d pending, want 0", expQ.size());
        else passCount++;
    endtask

    task automatic test_loop();
        int kind, doneBase, errBase;
        doneBase = doneSeen;
        errBase  = errorSeen;
        memData[0] = 8'h10; memNext[0] = 4'd1;
        memData[1] = 8'h20; memNext[1] = 4'd0;
        pushExpected(4'd0);
        checkCount++;
        if (expQ.size() != 16) $display("[TB] FAIL loop_model: got %0d expected items, want 16", expQ.size());
        else passCount++;
        applyStart(4'd0);
        waitEvent(100, kind);
        checkCount++;
        if (kind != 2) $display("[TB] FAIL loop_end: got kind=%0d, want 2 (error)", kind);
        else passCount++;
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL loop_idle: got busy=%b, want 0", busy);
        else passCount++;
        repeat (4) @(negedge clk);
        #1;
        checkCount++;
        if (errorSeen - errBase != 1 || doneSeen - doneBase != 0 || expQ.size() != 0)
            $display("[TB] FAIL loop_counts: got err=%0d done=%0d pending=%0d, want 1/0/0",
                     errorSeen - errBase, doneSeen - doneBase, expQ.size());
        else passCount++;
    endtask

    task automatic test_start_ignored();
        pushExpected(4'd3);
        applyStart(4'd3);
        @(negedge clk);
        start = 1'b1; headPtr = 4'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkCount++;
        if (memRdAddr !== 4'd7)
            $display("[TB] FAIL ign_addr: got addr=%h, want 7", memRdAddr);
        else passCount++;
        repeat (2) @(negedge clk);
        checkCount++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL ign_done_c7: got done=%b busy=%b, want 1/0", done, busy);
        else passCount++;
        #1;
        checkCount++;
        if (expQ.size() != 0) $display("[TB] FAIL ign_drain: got %0d pending, want 0", expQ.size());
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int kind, doneBase;
        pushExpected(4'd3);
        applyStart(4'd3);
        @(negedge clk);
        rstN = 1'b0;
        expQ.delete();
        doneBase = doneSeen;
        #1;
        checkCount++;
        if ({busy, memRdEn, memRdAddr, outValid, outData, outLast, done, error} !== '0)
            $display("[TB] FAIL rstmid_outputs: got busy=%b rden=%b addr=%h valid=%b data=%h last=%b done=%b err=%b, want all 0",
                     busy, memRdEn, memRdAddr, outValid, outData, outLast, done, error);
        else passCount++;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        checkCount++;
        if (done !== 1'b0 || busy !== 1'b0 || doneSeen != doneBase)
            $display("[TB] FAIL rstmid_no_done: got done=%b busy=%b count=%0d, want 0/0/0", done, busy, doneSeen - doneBase);
        else passCount++;
        pushExpected(4'd7);
        applyStart(4'd7);
        waitEvent(20, kind);
        checkCount++;
        if (kind != 1) $display("[TB] FAIL rstmid_restart: got kind=%0d, want 1 (done)", kind);
        else passCount++;
        #1;
        checkCount++;
        if (expQ.size() != 0 || doneSeen - doneBase != 1)
            $display("[TB] FAIL rstmid_drain: got pending=%0d done=%0d, want 0/1", expQ.size(), doneSeen - doneBase);
        else passCount++;
    endtask

    initial begin
        start    = 1'b0;
        headPtr  = '0;
        outReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            memData[i] = 8'(i * 17 + 5);
            memNext[i] = NULL_PTR;
        end
        memData[3] = 8'hA1; memNext[3] = 4'd7;
        memData[7] = 8'hB2; memNext[7] = NULL_PTR;

        test_reset();
        test_basic();
        test_empty();
        test_backpressure();
        test_loop();
        test_start_ignored();
        test_reset_mid();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
